// File: rtl/dram_cmd_initiator_if.sv
// Host request/response handshake between the arbiter and the DRAM initiator.
// The initiator owns req_ready and the response; the host owns the request.
interface dram_cmd_initiator_if #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
);
  localparam int BW = $clog2(NUM_OF_BANKS);
  localparam int RW = $clog2(NUM_OF_ROWS);

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [BW-1:0]          req_bank;
  logic [RW-1:0]          req_row;
  logic [NUM_OF_COLS-1:0] req_wdata;
  logic                   resp_valid;
  logic [NUM_OF_COLS-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_bank,
    output req_row, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_bank,
    input  req_row, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dram_cmd_initiator.sv
// Single-row read/write initiator for the bit-serial DRAM bank interface.
// Writes shift one column per cycle; reads activate, stream and assemble.
module dram_cmd_initiator #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
) (
  input  logic clk,
  input  logic rst_b,
  dram_cmd_initiator_if.slave host,
  output logic bank_rw,
  output logic buffer_rw,
  output logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
  output logic [$clog2(NUM_OF_ROWS)-1:0]  rowid,
  output logic [$clog2(NUM_OF_COLS)-1:0]  colid,
  inout  wire  data
);
  localparam int CW = $clog2(NUM_OF_COLS);
  localparam logic [CW-1:0] COL_LAST = CW'(NUM_OF_COLS - 1);

  typedef enum logic [2:0] {
    IDLE, WR, ACT, RD, RESP
  } state_t;

  state_t                 state;
  logic                   act_cnt;
  logic                   rd_last;
  logic [NUM_OF_COLS-1:0] wsh;
  logic [NUM_OF_COLS-1:0] rdata;

  // Bus released in the same cycle the write strobe falls.
  assign data = bank_rw ? wsh[0] : 1'bz;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state            <= IDLE;
      bank_rw          <= 1'b0;
      buffer_rw        <= 1'b0;
      bank_id          <= '0;
      rowid            <= '0;
      colid            <= '0;
      host.resp_valid  <= 1'b0;
      host.resp_rdata  <= '0;
      host.req_ready   <= 1'b1;
      act_cnt          <= 1'b0;
      rd_last          <= 1'b0;
      wsh              <= '0;
      rdata            <= '0;
    end else begin
      host.resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (host.req_valid && host.req_ready) begin
            bank_id        <= host.req_bank;
            rowid          <= host.req_row;
            host.req_ready <= 1'b0;
            if (host.req_we) begin
              state   <= WR;
              bank_rw <= 1'b1;
              colid   <= '0;
              wsh     <= host.req_wdata;
            end else begin
              state     <= ACT;
              buffer_rw <= 1'b1;
              act_cnt   <= 1'b0;
            end
          end
        end
        WR: begin
          if (colid == COL_LAST) begin
            state           <= RESP;
            bank_rw         <= 1'b0;
            host.resp_valid <= 1'b1;
            host.resp_rdata <= '0;
          end else begin
            colid <= colid + CW'(1);
            wsh   <= wsh >> 1;
          end
        end
        ACT: begin
          if (act_cnt) begin
            state     <= RD;
            buffer_rw <= 1'b0;
            colid     <= '0;
            rd_last   <= 1'b0;
          end else begin
            act_cnt <= 1'b1;
          end
        end
        RD: begin
          // Returned bit lags colid by one cycle, so skip the first slot.
          if (colid != '0 || rd_last) begin
            rdata <= {data, rdata[NUM_OF_COLS-1:1]};
          end
          if (rd_last) begin
            state           <= RESP;
            host.resp_valid <= 1'b1;
            host.resp_rdata <= {data, rdata[NUM_OF_COLS-1:1]};
          end else if (colid == COL_LAST) begin
            rd_last <= 1'b1;
          end else begin
            colid <= colid + CW'(1);
          end
        end
        RESP: begin
          state          <= IDLE;
          host.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_cmd_initiator.sv
// Randomised bench for dram_cmd_initiator with a bit-level DRAM bank model
// and a word-level reference memory predicting every response.
module tb_dram_cmd_initiator;
  localparam int NB = 8;
  localparam int NR = 128;
  localparam int NC = 8;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       bank_rw;
  logic       buffer_rw;
  logic [2:0] bank_id;
  logic [6:0] rowid;
  logic [2:0] colid;
  wire        data;

  dram_cmd_initiator_if #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)
  ) host ();

  dram_cmd_initiator #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .host      (host),
    .bank_rw   (bank_rw),
    .buffer_rw (buffer_rw),
    .bank_id   (bank_id),
    .rowid     (rowid),
    .colid     (colid),
    .data      (data)
  );

  always #5 clk = ~clk;

  // Undriven bus floats high so a released bus is observable.
  pullup (data);

  // DRAM bank model: bit writes, row-buffer load, registered read bit.
  logic [NC-1:0] mem_bits [NB][NR];
  logic [NC-1:0] rbuf;
  logic          drv;
  logic          rbit;
  logic          open_row;
  logic          mem_clear;

  assign data = drv ? rbit : 1'bz;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < NB; i++)
        for (int j = 0; j < NR; j++)
          mem_bits[i][j] <= '0;
      drv      <= 1'b0;
      open_row <= 1'b0;
      rbit     <= 1'b0;
      rbuf     <= '0;
    end else if (!rst_b) begin
      drv      <= 1'b0;
      open_row <= 1'b0;
    end else begin
      if (bank_rw) mem_bits[bank_id][rowid][colid] <= data;
      if (buffer_rw) begin
        rbuf     <= mem_bits[bank_id][rowid];
        open_row <= 1'b1;
      end else if (host.resp_valid) begin
        open_row <= 1'b0;
      end
      drv  <= open_row && !bank_rw && !buffer_rw && !host.resp_valid;
      rbit <= rbuf[colid];
    end
  end

  int acc_cnt = 0;
  always @(posedge clk) begin
    if (rst_b && host.req_valid && host.req_ready) acc_cnt <= acc_cnt + 1;
  end

  // Reference: whole-word memory image, updated per transaction.
  logic [NC-1:0] ref_mem [NB][NR];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_bank_rw"}, bank_rw, 0);
    chk({tag, "_buffer_rw"}, buffer_rw, 0);
    chk({tag, "_bank_id"}, bank_id, 0);
    chk({tag, "_rowid"}, rowid, 0);
    chk({tag, "_colid"}, colid, 0);
    chk({tag, "_resp_valid"}, host.resp_valid, 0);
    chk({tag, "_resp_rdata"}, host.resp_rdata, 0);
    chk({tag, "_req_ready"}, host.req_ready, 1);
    chk({tag, "_data_z"}, data, 1);
  endtask

  task automatic randomize_req();
    host.req_we    = 1'($urandom_range(0, 1));
    host.req_bank  = 3'($urandom_range(0, NB - 1));
    host.req_row   = 7'($urandom_range(0, NR - 1));
    host.req_wdata = 8'($urandom);
  endtask

  // Called just after a negedge in IDLE; returns after the next IDLE negedge.
  task automatic run_txn(input bit we, input int b, input int r,
                         input logic [NC-1:0] wd, input bit hold);
    int lat;
    int acc0;
    bit exp_bw;
    bit exp_buf;
    logic [NC-1:0] exp_rd;
    lat    = we ? NC + 1 : NC + 4;
    exp_rd = we ? '0 : ref_mem[b][r];
    host.req_valid = 1'b1;
    host.req_we    = we;
    host.req_bank  = b[2:0];
    host.req_row   = r[6:0];
    host.req_wdata = wd;
    acc0 = acc_cnt;
    @(posedge clk);
    for (int off = 1; off <= lat; off++) begin
      @(negedge clk);
      exp_bw  = we && off <= NC;
      exp_buf = !we && off <= 2;
      chk("bank_rw", bank_rw, exp_bw);
      chk("buffer_rw", buffer_rw, exp_buf);
      chk("req_ready_busy", host.req_ready, 0);
      chk("resp_valid", host.resp_valid, off == lat);
      chk("bank_id", bank_id, b);
      chk("rowid", rowid, r);
      chk("colid_max", colid <= NC - 1, 1);
      if (exp_bw) begin
        chk("wr_colid", colid, off - 1);
        chk("wr_data", data, wd[off-1]);
      end else if (!we && off >= 3) begin
        chk("rd_colid", colid, (off - 3 > NC - 1) ? NC - 1 : off - 3);
      end
      if (!exp_bw && !drv) chk("data_z", data, 1);
      if (off == lat) chk("resp_rdata", host.resp_rdata, exp_rd);
      if (hold) randomize_req();
      else host.req_valid = 1'b0;
    end
    @(negedge clk);
    chk("idle_ready", host.req_ready, 1);
    chk("idle_resp_valid", host.resp_valid, 0);
    chk("idle_strobes", {bank_rw, buffer_rw}, 0);
    chk("accept_once", acc_cnt - acc0, 1);
    if (we) ref_mem[b][r] = wd;
  endtask

  // Reset asserted during cycle E+at_off of a transaction.
  task automatic reset_mid(input bit we, input int b, input int r,
                           input logic [NC-1:0] wd, input int at_off);
    logic [NC-1:0] mask;
    host.req_valid = 1'b1;
    host.req_we    = we;
    host.req_bank  = b[2:0];
    host.req_row   = r[6:0];
    host.req_wdata = wd;
    @(posedge clk);
    for (int off = 1; off <= at_off; off++) begin
      @(negedge clk);
      host.req_valid = 1'b0;
    end
    rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset(we ? "rst_wr" : "rst_act");
    rst_b = 1'b1;
    repeat (14) begin
      @(negedge clk);
      chk("post_rst_resp_valid", host.resp_valid, 0);
      chk("post_rst_strobes", {bank_rw, buffer_rw}, 0);
    end
    if (we) begin
      mask = NC'((1 << (at_off - 1)) - 1);
      ref_mem[b][r] = (ref_mem[b][r] & ~mask) | (wd & mask);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < NR; j++)
        ref_mem[i][j] = '0;
    rst_b          = 1'b0;
    mem_clear      = 1'b1;
    host.req_valid = 1'b0;
    host.req_we    = 1'b0;
    host.req_bank  = '0;
    host.req_row   = '0;
    host.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_clear = 1'b0;
    check_reset("por");
    rst_b = 1'b1;
    @(negedge clk);

    run_txn(1, 3, 17, 8'hA5, 0);
    run_txn(0, 3, 17, 8'h00, 0);
    chk("a5_ref", ref_mem[3][17], 8'hA5);

    run_txn(1, 0, 5, 8'hFF, 0);
    run_txn(1, 1, 5, 8'h00, 0);
    run_txn(0, 0, 5, 8'h00, 0);
    run_txn(0, 1, 5, 8'h00, 0);
    run_txn(0, 2, 5, 8'h00, 0);

    run_txn(1, 7, 127, 8'h81, 0);
    run_txn(0, 7, 127, 8'h00, 0);

    for (int t = 0; t < 6; t++) begin
      run_txn(t % 2 == 0, 4, 40 + t / 2 * 0, 8'(8'h3C + t), 1);
    end
    host.req_valid = 1'b0;

    reset_mid(1, 6, 100, 8'hB7, 3);
    run_txn(0, 6, 100, 8'h00, 0);
    chk("partial_ref", ref_mem[6][100], 8'h03);

    run_txn(1, 2, 9, 8'h6E, 0);
    reset_mid(0, 2, 9, 8'h00, 1);
    run_txn(0, 2, 9, 8'h00, 0);

    for (int t = 0; t < 24; t++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom_range(0, NB - 1),
              $urandom_range(0, 3), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    host.req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dram_cmd_initiator.md
# dram_cmd_initiator

Host-side initiator for the bit-serial DRAM bank interface: it accepts single-row read/write requests from the controller core and drives the bank/buffer strobes, addresses and the shared 1-bit `data` bus. It sits between the request arbiter and the DRAM bank model in the testbench, or the DRAM pins in the real design. Writes are serialised one column bit per cycle. Reads activate the row into the bank's row buffer, then stream the buffered bits back and assemble them into one word.

## Interface
- `NUM_OF_BANKS`, 8, number of banks; `bank_id` width = clog2.
- `NUM_OF_ROWS`, 128, rows per bank; `rowid` width = clog2.
- `NUM_OF_COLS`, 8, columns per row; this is also the host data word width in bits.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all logic on posedge.
- `rst_b`  in  1  synchronous active-low reset.
- `req_valid`  in  1  host request present.
- `req_ready`  out  1  high only in IDLE; request accepted on an edge where `req_valid && req_ready`.
- `req_we`  in  1  1 = write row, 0 = read row.
- `req_bank`  in  clog2(NUM_OF_BANKS)  target bank.
- `req_row`  in  clog2(NUM_OF_ROWS)  target row.
- `req_wdata`  in  NUM_OF_COLS  write data; bit c goes to column c.
- `resp_valid`  out  1  one-cycle completion pulse for both reads and writes.
- `resp_rdata`  out  NUM_OF_COLS  read data; valid with `resp_valid`; 0 for writes.
- `bank_rw`  out  1  DRAM bank write strobe.
- `buffer_rw`  out  1  DRAM row-buffer load strobe.
- `bank_id`  out  clog2(NUM_OF_BANKS)  DRAM bank address.
- `rowid`  out  clog2(NUM_OF_ROWS)  DRAM row address.
- `colid`  out  clog2(NUM_OF_COLS)  DRAM column address.
- `data`  inout  1  shared data bit. Driven by this block only while `bank_rw`=1, otherwise Z.

## Operation
- All DRAM-side outputs and `resp_*` are registered.
- Request fields are captured into internal registers at acceptance. Host inputs are ignored outside IDLE.
- FSM states: IDLE, WR, ACT, RD, RESP.
- IDLE: `bank_rw`=`buffer_rw`=0 and addresses hold their last values.
  - Accept with `req_we`=1 goes to WR.
  - Accept with `req_we`=0 goes to ACT.
- WR: lasts NUM_OF_COLS cycles.
  - `bank_rw`=1, `bank_id`/`rowid` = captured values.
  - `colid` = 0,1,…,NUM_OF_COLS-1; `data` = `wdata[colid]`.
  - Goes to RESP after the last column.
- ACT: exactly 2 cycles.
  - `buffer_rw`=1, `bank_rw`=0, `bank_id`/`rowid` = captured values.
  - The DRAM row-buffer load is two-stage, so one cycle is insufficient.
- RD: lasts NUM_OF_COLS+1 cycles, with `buffer_rw`=`bank_rw`=0.
  - In RD cycle k (k=0..NUM_OF_COLS-1), `colid`=k. In the final cycle, `colid` holds NUM_OF_COLS-1.
  - The DRAM returns the bit for `colid` one cycle later (registered output).
  - At the end of RD cycle k (k≥1), `data` is sampled into `rdata[k-1]`.
  - Goes to RESP.
- RESP: 1 cycle. `resp_valid`=1; `resp_rdata` = assembled word for reads, 0 for writes. Goes to IDLE.
- `colid` counter:
  - Width clog2(NUM_OF_COLS); no wrap beyond NUM_OF_COLS-1.
  - Terminal count is detected by compare, not overflow, so non-power-of-2 NUM_OF_COLS works.
- No request queueing and no back-to-back overlap. The next request is accepted at the earliest in the IDLE cycle after RESP.

## Timing
- Reset (`rst_b`=0 at an edge) takes effect after that edge:
  - state=IDLE.
  - `bank_rw`=`buffer_rw`=0; `bank_id`=`rowid`=`colid`=0.
  - `resp_valid`=0, `resp_rdata`=0, `req_ready`=1, `data`=Z.
- Reset mid-operation aborts the transfer immediately: no `resp_valid` and no further strobes. A partially written row is left as-is.
- Write latency, with acceptance edge E:
  - WR occupies cycles E+1..E+NUM_OF_COLS.
  - `resp_valid` is high in cycle E+NUM_OF_COLS+1 (cycle 9 for the default).
- Read latency, with acceptance edge E:
  - ACT occupies E+1..E+2.
  - RD occupies E+3..E+NUM_OF_COLS+3.
  - `resp_valid` is high in cycle E+NUM_OF_COLS+4 (cycle 12 for the default).
- `req_ready` is 0 from the cycle after acceptance through RESP, and 1 again in the cycle after RESP.
- Bus turnaround: `data` is released (Z) in the same cycle `bank_rw` falls. This block never drives while `buffer_rw`=1 or in RD.
- `req_valid` held high continuously: the next request is accepted on the first edge in IDLE.

## Test plan
- Write 0xA5 to bank 3 row 17, then read bank 3 row 17 -> `resp_rdata`=0xA5.
  - Write `resp_valid` at E+9; read `resp_valid` at E+12.
  - `colid` sequence 0..7 during WR with `data` bits 1,0,1,0,0,1,0,1.
- Bank isolation: write 0xFF to bank 0 row 5 and 0x00 to bank 1 row 5; read both -> 0xFF and 0x00. Read bank 2 row 5 -> 0x00.
- Address extremes: write 0x81 to bank 7 row 127, then read -> 0x81. `colid` never exceeds 7.
- `req_valid` held high with alternating write/read requests:
  - Exactly one acceptance per transaction; `req_ready` low throughout each.
  - No strobe overlap; `data` is Z whenever `bank_rw`=0.
- `rst_b` low on the 3rd WR cycle:
  - Next cycle: all outputs at reset values, `data`=Z, no `resp_valid`.
  - A following read of that row returns the first two bits written and the remaining bits 0.
- Reset during ACT: `buffer_rw`=0 the next cycle, FSM returns to IDLE, and a new read request completes normally.
